bnn_mem_reader: RTL and testbench
=================================

# bnn_mem_reader

Read-side sequencer for `mem_sys`. On `start`, it walks the activation bank (x port) and the weight bank (w port) in neuron-major order: for each output neuron j, it reads every input index i. It streams each (x[i], w[j][i]) bit pair to the downstream XNOR/popcount datapath over a valid/ready handshake. It is the consumer-side counterpart of the file loader that fills `mem_sys` through `we_x`/`we_w`/`data_in`, and it never writes memory.

## Interface
- `X_AW`, 10, x address width (matches `mem_sys` `address_x`)
- `W_AW`, 20, w address width (matches `mem_sys` `address_w`)
- `NI_W`, 11, width of `n_in` (max 1024 inputs)
- `NO_W`, 10, width of `n_out` (max 1023 neurons)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  launch a pass; sampled only in IDLE
- `n_in`  in  NI_W  inputs per neuron; latched on start
- `n_out`  in  NO_W  neuron count; latched on start
- `x_base`  in  X_AW  first x address; latched on start
- `w_base`  in  W_AW  first w address; latched on start
- `sel_x_cfg`, `sel_w_cfg`  in  2 each  bank selects; latched on start
- `we_x`, `we_w`  out  1 each  memory write enables; tied 0
- `address_x`  out  X_AW  x read address (registered)
- `address_w`  out  W_AW  w read address (registered)
- `sel_x`, `sel_w`  out  2 each  latched bank selects
- `data_out_x`, `data_out_w`  in  1 each  memory read data, valid 1 cycle after address
- `out_valid`  out  1  pair available
- `out_ready`  in  1  downstream accepts pair
- `out_x`, `out_w`  out  1 each  pair bits
- `out_last_in`  out  1  pair has i = n_in-1 (end of neuron)
- `out_last`  out  1  final pair of the pass
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle pulse at end of pass

## Operation
- FSM: IDLE → RUN on `start` when `n_in`≠0 and `n_out`≠0. IDLE → DONE on `start` when either count is 0; no reads and no pairs in that case.
- RUN → DRAIN when the last read (i=n_in-1, j=n_out-1) issues.
- DRAIN → DONE when the output buffer is empty and no read is in flight.
- DONE → IDLE unconditionally. `done` is high only in DONE.
- Read counters: i runs 0..n_in-1. On wrap, i resets to 0 and j increments.
- `address_x` = `x_base`+i, modulo 2^X_AW.
- `address_w` advances by +1 per issue from `w_base` using a running pointer, with no multiplier. It wraps modulo 2^W_AW.
- Every issued read carries tags `last_in` (i=n_in-1) and `last` (also j=n_out-1) through a 1-cycle in-flight register.
- Output buffer: 2-entry FIFO of {x, w, last_in, last}. It captures `data_out_x`/`data_out_w` plus tags on the edge after issue. Head drives `out_*`.
- Pop when `out_valid && out_ready`.
- Issue rule: issue in RUN iff (fifo_count + inflight − pop) < 2. This guarantees no overflow and one pair per cycle under continuous `out_ready`.
- When a cycle does not issue, addresses hold their value.
- Out-of-range note: `mem_sys` responds to any address; the block does no bounds checking.
- `start` while busy, or in DONE, is ignored. Config inputs are ignored outside the IDLE start edge.

## Timing
- Reset (`rst`=1 at posedge): state IDLE, FIFO and in-flight cleared. All outputs go to 0 next cycle: `address_x`, `address_w`, `sel_x`, `sel_w`, `out_*`, `busy`, `done`. `we_x`/`we_w` are always 0.
- Reset mid-pass: aborts the pass, drops any buffered pair, and no `done` pulse follows.
- Cycle 0: `start` sampled.
- Cycle 1: `busy`=1, `address_x`=`x_base`, `address_w`=`w_base`, `sel_*` valid.
- Cycle 2: `out_valid`=1 with pair (0,0).
- Pair handshakes when `out_valid && out_ready` at posedge. Data is held stable while `out_valid && !out_ready`.
- Throughput with `out_ready`=1: one pair per cycle, N = n_in·n_out pairs in cycles 2..N+1. `done` pulses in cycle N+2, IDLE in cycle N+3.
- Backpressure: at most 2 pairs buffered. Issue resumes the cycle `out_ready` rises, with no bubble beyond the 1-cycle read latency.

## Test plan
- Preload x[0..2]=1,0,1 and w[0..5]=1,1,0,0,1,0; n_in=3, n_out=2, bases 0, `out_ready`=1.
  - Expect pairs (1,1),(0,1),(1,0),(1,0),(0,1),(1,0) in cycles 2–7.
  - Expect `out_last_in` on pairs 3 and 6, `out_last` on pair 6 only.
  - Expect `done` in cycle 8.
- Same load with `out_ready` toggled 1,0,0,1,...
  - Expect the same 6-pair sequence with no loss or duplication.
  - Expect `address_x` to advance at most 2 ahead of the last accepted pair.
- n_in=0 (or n_out=0) with `start` → `busy` stays 0, no `out_valid`, `done` in cycle 1.
- x_base=1022, n_in=4 → x addresses 1022,1023,0,1. w_base=2^20−2 → w address wraps to 0.
- Assert `rst` during the 4th cycle of a 1024×4 pass → next cycle all outputs 0 and no `done`. A new `start` then runs cleanly from i=0, j=0.
- Pulse `start` mid-pass with different config → ignored, and the pass completes with the original counts and bases.

Source files
------------

// File: rtl/bnn_mem_reader.sv
// bnn_mem_reader: read-side sequencer for mem_sys.
// On start, walks x and w banks neuron-major (for each neuron j, every input i)
// and streams (x[i], w[j][i]) bit pairs downstream over valid/ready.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, n_in, n_out,
//   x_base, w_base,
//   sel_x_cfg, sel_w_cfg: pass launch and config (latched on start in IDLE)
//   we_x, we_w          : memory write enables, always 0
//   address_x/_w, sel_x/_w : registered read address / latched bank selects
//   data_out_x/_w       : memory read data, valid the cycle after address changes
//   out_valid/out_ready : pair handshake; out_x/out_w/out_last_in/out_last payload
//   busy, done          : busy in RUN/DRAIN, done one-cycle pulse at end of pass
module bnn_mem_reader #(
  parameter int X_AW = 10,
  parameter int W_AW = 20,
  parameter int NI_W = 11,
  parameter int NO_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NI_W-1:0] n_in,
  input  logic [NO_W-1:0] n_out,
  input  logic [X_AW-1:0] x_base,
  input  logic [W_AW-1:0] w_base,
  input  logic [1:0]      sel_x_cfg,
  input  logic [1:0]      sel_w_cfg,
  output logic            we_x,
  output logic            we_w,
  output logic [X_AW-1:0] address_x,
  output logic [W_AW-1:0] address_w,
  output logic [1:0]      sel_x,
  output logic [1:0]      sel_w,
  input  logic            data_out_x,
  input  logic            data_out_w,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_x,
  output logic            out_w,
  output logic            out_last_in,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic x;
    logic w;
    logic last_in;
    logic last;
  } pair_t;

  state_t          state;
  logic [NI_W-1:0] nin_q, i_cnt;
  logic [NO_W-1:0] nout_q, j_cnt;
  logic [X_AW-1:0] xb_q;

  // One read in flight between address register and FIFO capture.
  logic            infl_v, infl_li, infl_l;

  pair_t           fifo_q [2];
  logic            rd_ptr, wr_ptr;
  logic [1:0]      cnt;

  logic            pop, start_ok, issue, room, drain_empty;
  logic            last_in, last;
  logic [NI_W-1:0] cur_i, cur_nin;
  logic [NO_W-1:0] cur_j, cur_nout;

  assign we_x        = 1'b0;
  assign we_w        = 1'b0;
  assign out_valid   = (cnt != 2'd0);
  assign out_x       = fifo_q[rd_ptr].x;
  assign out_w       = fifo_q[rd_ptr].w;
  assign out_last_in = fifo_q[rd_ptr].last_in;
  assign out_last    = fifo_q[rd_ptr].last;
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);

  assign pop      = out_valid && out_ready;
  assign start_ok = (state == IDLE) && start && (n_in != '0) && (n_out != '0);

  // The start edge itself issues read (0,0), so the first address shows in
  // cycle 1; in IDLE the "current" indices/counts come straight from the ports.
  always_comb begin
    cur_i    = i_cnt;
    cur_j    = j_cnt;
    cur_nin  = nin_q;
    cur_nout = nout_q;
    if (state == IDLE) begin
      cur_i    = '0;
      cur_j    = '0;
      cur_nin  = n_in;
      cur_nout = n_out;
    end
  end

  assign last_in = (cur_i == cur_nin - NI_W'(1));
  assign last    = last_in && (cur_j == cur_nout - NO_W'(1));

  // Occupancy after this edge (buffered + in flight - popped) must leave a slot.
  assign room        = ({1'b0, cnt} + {2'b0, infl_v} - {2'b0, pop}) < 3'd2;
  assign issue       = start_ok || ((state == RUN) && room);
  // Finish the cycle the last pair leaves, so done lands at N+2.
  assign drain_empty = !infl_v && (cnt == {1'b0, pop});

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      nin_q     <= '0;
      nout_q    <= '0;
      xb_q      <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      address_x <= '0;
      address_w <= '0;
      sel_x     <= '0;
      sel_w     <= '0;
      infl_v    <= 1'b0;
      infl_li   <= 1'b0;
      infl_l    <= 1'b0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      cnt       <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          nin_q  <= n_in;
          nout_q <= n_out;
          xb_q   <= x_base;
          sel_x  <= sel_x_cfg;
          sel_w  <= sel_w_cfg;
          if (start_ok) state <= last ? DRAIN : RUN;
          else          state <= DONE;
        end
        RUN:   if (issue && last) state <= DRAIN;
        DRAIN: if (drain_empty)   state <= DONE;
        default: state <= IDLE;
      endcase

      infl_v <= issue;
      if (issue) begin
        address_x <= ((state == IDLE) ? x_base : xb_q) + X_AW'(cur_i);
        // Running pointer: w address is just the previous one plus one.
        address_w <= (state == IDLE) ? w_base : address_w + W_AW'(1);
        i_cnt     <= last_in ? '0 : cur_i + NI_W'(1);
        j_cnt     <= last_in ? cur_j + NO_W'(1) : cur_j;
        infl_li   <= last_in;
        infl_l    <= last;
      end

      if (pop) rd_ptr <= ~rd_ptr;
      if (infl_v) begin
        fifo_q[wr_ptr] <= '{x: data_out_x, w: data_out_w, last_in: infl_li, last: infl_l};
        wr_ptr         <= ~wr_ptr;
      end
      cnt <= cnt + {1'b0, infl_v} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_bnn_mem_reader.sv
// Bench for bnn_mem_reader: memory model, pair-sequence model, directed passes.
module tb_bnn_mem_reader;
  localparam int X_AW = 10, W_AW = 20, NI_W = 11, NO_W = 10;

  logic clk = 0, rst = 1, start = 0, out_ready = 1;
  logic [NI_W-1:0] n_in = '0;
  logic [NO_W-1:0] n_out = '0;
  logic [X_AW-1:0] x_base = '0;
  logic [W_AW-1:0] w_base = '0;
  logic [1:0] sel_x_cfg = '0, sel_w_cfg = '0;
  logic we_x, we_w, data_out_x, data_out_w, out_valid, out_x, out_w;
  logic out_last_in, out_last, busy, done;
  logic [X_AW-1:0] address_x;
  logic [W_AW-1:0] address_w;
  logic [1:0] sel_x, sel_w;

  bnn_mem_reader #(.X_AW(X_AW), .W_AW(W_AW), .NI_W(NI_W), .NO_W(NO_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in), .n_out(n_out),
    .x_base(x_base), .w_base(w_base), .sel_x_cfg(sel_x_cfg), .sel_w_cfg(sel_w_cfg),
    .we_x(we_x), .we_w(we_w), .address_x(address_x), .address_w(address_w),
    .sel_x(sel_x), .sel_w(sel_w), .data_out_x(data_out_x), .data_out_w(data_out_w),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_w(out_w),
    .out_last_in(out_last_in), .out_last(out_last), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int rmode = 0, ph = 0, hs = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: x array, w as preloaded low words plus a parity pattern elsewhere.
  bit xmem [0:1023];
  initial for (int a = 0; a < 1024; a++) xmem[a] = (a < 3) ? (a != 1) : (a[0] ^ a[3] ^ a[7]);

  function automatic bit wbit(input logic [W_AW-1:0] a);
    case (a)
      20'd0: return 1'b1;
      20'd1: return 1'b1;
      20'd2: return 1'b0;
      20'd3: return 1'b0;
      20'd4: return 1'b1;
      20'd5: return 1'b0;
      default: return ^(a & 20'h5A5A5);
    endcase
  endfunction

  assign data_out_x = xmem[address_x];
  assign data_out_w = wbit(address_w);

  // Expected pair stream {x, w, last_in, last} in neuron-major order.
  logic [3:0] expq [$];
  logic [3:0] acc  [$];

  task automatic build(input int nin, input int nout, input int xb, input int wb);
    expq.delete();
    for (int j = 0; j < nout; j++)
      for (int i = 0; i < nin; i++) begin
        int xa, wa;
        xa = (xb + i) % 1024;
        wa = (wb + j * nin + i) % (1 << 20);
        expq.push_back({xmem[xa], wbit(W_AW'(wa)), (i == nin - 1), (i == nin - 1) && (j == nout - 1)});
      end
  endtask

  always @(negedge clk) begin
    if (rst) expq.delete();
    else begin
      check("we_tied", {we_x, we_w}, 0);
      if (out_valid) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_pair: got %b expected none (t=%0t)",
                   {out_x, out_w, out_last_in, out_last}, $time);
        end else begin
          check("pair", {out_x, out_w, out_last_in, out_last}, expq[0]);
          if (out_ready) begin
            acc.push_back({out_x, out_w, out_last_in, out_last});
            void'(expq.pop_front());
          end
        end
      end
    end
  end

  always @(posedge clk) if (!rst && out_valid && out_ready) hs++;

  // out_ready: steady 1, or the 1,0,0,1 pattern.
  initial forever begin
    @(posedge clk); #1;
    out_ready = (rmode == 0) ? 1'b1 : ((ph % 4 == 0) || (ph % 4 == 3));
    ph++;
  end

  task automatic check_zero(input string name);
    check(name, {address_x, address_w, sel_x, sel_w, out_valid, out_x, out_w,
                 out_last_in, out_last, busy, done}, 0);
  endtask

  logic [X_AW-1:0] alog [$];
  logic [W_AW-1:0] wlog [$];

  // g: cycle to pulse a stray start with other config; r: cycle to assert rst.
  task automatic run_pass(input int nin, input int nout, input int xb, input int wb,
                          input int rm, input int g, input int r);
    int dcyc, issued, maxd, hs0, nn;
    bit seen_busy;
    logic [X_AW-1:0] pax;
    logic [1:0] sx, sw;
    nn = nin * nout;
    sx = 2'($urandom_range(1, 3)); sw = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    rmode = rm; ph = 0;
    n_in = NI_W'(nin); n_out = NO_W'(nout); x_base = X_AW'(xb); w_base = W_AW'(wb);
    sel_x_cfg = sx; sel_w_cfg = sw; start = 1;
    build(nin, nout, xb, wb);
    acc.delete(); alog.delete(); wlog.delete();
    hs0 = hs; dcyc = -1; issued = 0; maxd = 0; seen_busy = 0; pax = '0;
    for (int c = 1; c <= 3000 && dcyc < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 0;
      if (g > 0 && c == g) begin
        start = 1; n_in = 7; n_out = 9; x_base = 5; w_base = 77;
        sel_x_cfg = ~sx; sel_w_cfg = ~sw;
      end
      if (g > 0 && c == g + 1) start = 0;
      if (r > 0 && c == r) rst = 1;
      if (r > 0 && c == r + 1) rst = 0;
      @(negedge clk);
      if (r > 0 && c == r + 1) begin
        check_zero("reset_mid_pass");
        break;
      end
      if (c == 1 && nn != 0)
        check("cycle1", {busy, address_x, address_w, sel_x, sel_w},
              {1'b1, X_AW'(xb), W_AW'(wb), sx, sw});
      if (busy) begin
        seen_busy = 1;
        alog.push_back(address_x); wlog.push_back(address_w);
        if (c == 1) issued = 1;
        else if (address_x != pax) issued++;
        pax = address_x;
        if (issued - (hs - hs0) > maxd) maxd = issued - (hs - hs0);
      end
      if (done) dcyc = c;
    end
    if (r > 0) begin
      int nd = 0;
      repeat (12) begin @(negedge clk); if (done || busy) nd++; end
      check("no_done_after_reset", nd, 0);
    end else if (dcyc < 0) begin
      checks++; errors++;
      $display("FAIL timeout: got no done expected done within 3000 cycles");
    end else begin
      check("drained", expq.size(), 0);
      check("accepted", acc.size(), nn);
      if (nn == 0) check("zero_busy", seen_busy, 0);
      if (rm == 0) check("done_cycle", dcyc, (nn == 0) ? 1 : nn + 2);
      if (rm == 1) begin
        checks++;
        if (maxd > 2) begin
          errors++;
          $display("FAIL ahead: got %0d expected at most 2", maxd);
        end
      end
    end
  endtask

  logic [3:0] lit [6] = '{4'b1100, 4'b0100, 4'b1010, 4'b1000, 4'b0100, 4'b1011};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk); #1 rst = 0;

    // Test-plan load, continuous ready; literal pair/tag sequence.
    run_pass(3, 2, 0, 0, 0, 0, 0);
    check("t1_count", acc.size(), 6);
    for (int k = 0; k < 6 && k < acc.size(); k++) check("t1_lit", acc[k], lit[k]);

    // Same load with ready 1,0,0,1,...
    run_pass(3, 2, 0, 0, 1, 0, 0);
    check("t2_count", acc.size(), 6);
    for (int k = 0; k < 6 && k < acc.size(); k++) check("t2_lit", acc[k], lit[k]);

    // Zero counts: straight to done.
    run_pass(0, 5, 0, 0, 0, 0, 0);
    run_pass(4, 0, 0, 0, 0, 0, 0);

    // Address wrap on both banks.
    run_pass(4, 1, 1022, (1 << 20) - 2, 0, 0, 0);
    check("wrap_len", alog.size() >= 4, 1);
    if (alog.size() >= 4) begin
      check("ax0", alog[0], 1022); check("ax1", alog[1], 1023);
      check("ax2", alog[2], 0);    check("ax3", alog[3], 1);
      check("aw0", wlog[0], 20'hFFFFE); check("aw1", wlog[1], 20'hFFFFF);
      check("aw2", wlog[2], 0);         check("aw3", wlog[3], 1);
    end

    // Reset mid-pass, then a clean pass.
    run_pass(1024, 4, 0, 0, 0, 0, 4);
    run_pass(5, 3, 10, 100, 1, 0, 0);

    // Stray start mid-pass is ignored.
    run_pass(3, 2, 2, 3, 0, 3, 0);

    // Single input per neuron and single-pair pass.
    run_pass(1, 3, 7, 9, 1, 0, 0);
    run_pass(1, 1, 4, 4, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
